ctx_quant_pred: RTL and testbench
=================================

Name: ctx_quant_pred

Overview:
- Downstream of the pixel neighbourhood extractor; consumes one neighbourhood (Ra, Rb, Rc, Rd, Rx) per accepted beat.
- Computes signed local gradients and quantises them to context indices, then merges the sign.
- Also computes the median-edge-detector (MED) prediction Px, the sign-corrected prediction error, and a run-mode flag.
- Results feed the context-statistics/Golomb coding stage through a 3-stage valid/ready pipeline with backpressure.

Parameters:
- DW, 16: pixel width in bits.
- T1, 3: gradient quantisation threshold 1.
- T2, 7: gradient quantisation threshold 2.
- T3, 21: gradient quantisation threshold 3.
- IMAGE_W, 11: pixels per line.
- IMAGE_H, 9: lines per frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  neighbourhood beat valid.
- in_ready  out  1  stage can accept a beat.
- ra, rb, rc, rd, rx  in  DW each  neighbour pixels and current pixel, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- ctx_idx  out  9  merged context index, 0..364.
- ctx_sign  out  1  1 = context was negated.
- run_flag  out  1  all three quantised gradients are zero.
- px  out  DW  MED prediction.
- errval  out  DW+1  signed (rx - px), negated when ctx_sign=1.
- out_last  out  1  marks the final pixel of a frame (IMAGE_W*IMAGE_H-th output).

Behaviour:
- Reset: all pipeline valid bits = 0.
  - out_valid = 0, in_ready = 1.
  - All data outputs = 0; pixel counter = 0.
- Handshake: a transfer occurs on a clk edge where valid && ready.
- Each stage register holds a valid bit and loads when it is empty or its successor takes its data in the same cycle.
  - in_ready = !v1 || load2.
  - load2 = v1 && (!v2 || load3).
  - load3 = v2 && (!v3 || out_ready).
  - out_valid = v3.
- Latency: 3 cycles from input accept to out_valid when not stalled. Throughput is 1 per cycle.
- Ordering is preserved. No beat is dropped or duplicated under any out_ready pattern.
- Outputs hold stable while out_valid && !out_ready.
- Stage 1 (gradients and MED):
  - D1 = rd - rb, D2 = rb - rc, D3 = rc - ra, each signed DW+1 bits.
  - mx = max(ra, rb), mn = min(ra, rb).
  - px = mn if rc >= mx; px = mx if rc <= mn; otherwise px = ra + rb - rc, computed in DW+2 bits and truncated to DW (always within [mn, mx]).
  - When ra == rb == rc, the first rule applies.
  - rx is carried forward with the stage.
- Stage 2 (quantisation), per Di, first match wins:
  - Di <= -T3 → -4
  - Di <= -T2 → -3
  - Di <= -T1 → -2
  - Di < 0 → -1
  - Di == 0 → 0
  - Di < T1 → 1
  - Di < T2 → 2
  - Di < T3 → 3
  - otherwise → 4
  - Qi is 4-bit signed. e = rx - px, signed DW+1.
- Stage 3 (merge and index):
  - ctx_sign = 1 if the first nonzero of (Q1, Q2, Q3) is negative; then Q1, Q2, Q3 and e are all negated.
  - All-zero gives ctx_sign = 0 and run_flag = 1.
  - ctx_idx = 81*Q1 + 9*Q2 + Q3, using the merged values; the result is always in 0..364.
  - errval = merged e. Negating the most negative value cannot occur because |e| < 2^DW.
- Pixel counter:
  - Increments on each output transfer (out_valid && out_ready).
  - out_last = 1 when the count equals IMAGE_W*IMAGE_H-1 and out_valid = 1.
  - Wraps to 0 on the transfer carrying out_last.
- Reset mid-operation: all in-flight beats are discarded and the counter is cleared. The next accepted beat is pixel 0 of a new frame.

Test Plan:
- ra=rb=rc=rd=100, rx=105 → after 3 cycles: ctx_idx=0, ctx_sign=0, run_flag=1, px=100, errval=5.
- ra=10, rb=50, rc=5, rd=80, rx=40 → Q=(4,4,-2): ctx_idx=358, ctx_sign=0, run_flag=0, px=50, errval=-10.
- ra=50, rb=50, rc=60, rd=48, rx=47 → raw Q=(-1,-3,3), merged (1,3,-3): ctx_idx=105, ctx_sign=1, px=50, errval=3.
- Threshold edges, with rb=rc=ra=1000 and rd = 1000 + {-21, -7, -3, -1, 0, 2, 6, 20, 21} → Q1 = -4, -3, -2, -1, 0, 1, 2, 3, 4. ctx_sign=1 for the negative cases, so ctx_idx = 81*|Q1|.
- Stream 8 beats with out_ready low for cycles 2-7 → in_ready falls once 3 beats are held. All 8 outputs arrive in order with no loss or duplication, and outputs stay stable while stalled.
- Stream 99 beats with out_ready=1 → out_last pulses only with the 99th output, and the 100th output has out_last=0. Asserting rst_n low mid-stream → out_valid=0 next edge, and the counter restarts.

Source files
------------

// File: rtl/ctx_quant_pred.sv
// ctx_quant_pred: local gradients -> quantised, sign-merged context index; MED prediction and sign-corrected error.
// Latency: 3 cycles from input accept to out_valid when not stalled; one beat per cycle sustained.
// Backpressure: each stage loads when empty or when its successor drains it; in_ready falls once all 3 stages hold data.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          neighbourhood handshake; ra, rb, rc, rd (neighbours), rx (current pixel), unsigned DW
//   out_valid/out_ready        result handshake
//   ctx_idx (0..364), ctx_sign, run_flag, px, errval (signed DW+1), out_last (final pixel of a frame)
module ctx_quant_pred #(
    parameter int DW      = 16,
    parameter int T1      = 3,
    parameter int T2      = 7,
    parameter int T3      = 21,
    parameter int IMAGE_W = 11,
    parameter int IMAGE_H = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] ra,
    input  logic [DW-1:0] rb,
    input  logic [DW-1:0] rc,
    input  logic [DW-1:0] rd,
    input  logic [DW-1:0] rx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [8:0]    ctx_idx,
    output logic          ctx_sign,
    output logic          run_flag,
    output logic [DW-1:0] px,
    output logic [DW:0]   errval,
    output logic          out_last
);

    localparam int NPIX = IMAGE_W * IMAGE_H;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    // Thresholds at gradient width so the comparisons stay width-matched.
    localparam logic signed [DW:0] T1S = (DW+1)'(T1);
    localparam logic signed [DW:0] T2S = (DW+1)'(T2);
    localparam logic signed [DW:0] T3S = (DW+1)'(T3);

    // Pipeline control
    logic v1, v2, v3;
    logic load2, load3;

    assign load3     = v2 && (!v3 || out_ready);
    assign load2     = v1 && (!v2 || load3);
    assign in_ready  = !v1 || load2;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (in_ready)            v1 <= in_valid;
            if (!v2 || load3)        v2 <= v1;
            if (!v3 || out_ready)    v3 <= v2;
        end
    end

    // ---------------- Stage 1: gradients and MED prediction ----------------
    logic signed [DW:0] d1_c, d2_c, d3_c;
    logic [DW-1:0]      mx_c, mn_c, px_c;
    logic [DW+1:0]      plane_c;

    // Zero-extended subtraction in DW+1 bits gives the exact signed difference.
    assign d1_c = $signed({1'b0, rd} - {1'b0, rb});
    assign d2_c = $signed({1'b0, rb} - {1'b0, rc});
    assign d3_c = $signed({1'b0, rc} - {1'b0, ra});

    assign mx_c    = (ra > rb) ? ra : rb;
    assign mn_c    = (ra > rb) ? rb : ra;
    assign plane_c = {2'b00, ra} + {2'b00, rb} - {2'b00, rc};

    // rc >= mx is tested first so a flat neighbourhood resolves to mn.
    always_comb begin
        px_c = plane_c[DW-1:0];
        if (rc >= mx_c)
            px_c = mn_c;
        else if (rc <= mn_c)
            px_c = mx_c;
    end

    logic signed [DW:0] d1_s1, d2_s1, d3_s1;
    logic [DW-1:0]      px_s1, rx_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_s1 <= '0;
            d2_s1 <= '0;
            d3_s1 <= '0;
            px_s1 <= '0;
            rx_s1 <= '0;
        end else if (in_valid && in_ready) begin
            d1_s1 <= d1_c;
            d2_s1 <= d2_c;
            d3_s1 <= d3_c;
            px_s1 <= px_c;
            rx_s1 <= rx;
        end
    end

    // ---------------- Stage 2: quantisation and raw error ----------------
    function automatic logic signed [3:0] quant(input logic signed [DW:0] d);
        logic signed [3:0] q;
        if      (d <= -T3S) q = -4'sd4;
        else if (d <= -T2S) q = -4'sd3;
        else if (d <= -T1S) q = -4'sd2;
        else if (d <  0)    q = -4'sd1;
        else if (d == 0)    q =  4'sd0;
        else if (d <  T1S)  q =  4'sd1;
        else if (d <  T2S)  q =  4'sd2;
        else if (d <  T3S)  q =  4'sd3;
        else                q =  4'sd4;
        return q;
    endfunction

    logic signed [3:0]  q1_s2, q2_s2, q3_s2;
    logic signed [DW:0] e_s2;
    logic [DW-1:0]      px_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_s2 <= '0;
            q2_s2 <= '0;
            q3_s2 <= '0;
            e_s2  <= '0;
            px_s2 <= '0;
        end else if (load2) begin
            q1_s2 <= quant(d1_s1);
            q2_s2 <= quant(d2_s1);
            q3_s2 <= quant(d3_s1);
            e_s2  <= $signed({1'b0, rx_s1} - {1'b0, px_s1});
            px_s2 <= px_s1;
        end
    end

    // ---------------- Stage 3: sign merge and context index ----------------
    logic               neg_c, zero_c;
    logic signed [3:0]  m1_c, m2_c, m3_c;
    logic signed [10:0] m1x_c, m2x_c, m3x_c, idx_c;

    // Context is negated when its first nonzero component is negative.
    assign neg_c  = (q1_s2 < 0) ||
                    ((q1_s2 == 0) && (q2_s2 < 0)) ||
                    ((q1_s2 == 0) && (q2_s2 == 0) && (q3_s2 < 0));
    assign zero_c = (q1_s2 == 0) && (q2_s2 == 0) && (q3_s2 == 0);

    assign m1_c = neg_c ? -q1_s2 : q1_s2;
    assign m2_c = neg_c ? -q2_s2 : q2_s2;
    assign m3_c = neg_c ? -q3_s2 : q3_s2;

    assign m1x_c = {{7{m1_c[3]}}, m1_c};
    assign m2x_c = {{7{m2_c[3]}}, m2_c};
    assign m3x_c = {{7{m3_c[3]}}, m3_c};
    // After merging the index is non-negative and at most 364, so 9 bits suffice.
    assign idx_c = 11'sd81 * m1x_c + 11'sd9 * m2x_c + m3x_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_idx  <= '0;
            ctx_sign <= 1'b0;
            run_flag <= 1'b0;
            px       <= '0;
            errval   <= '0;
        end else if (load3) begin
            ctx_idx  <= idx_c[8:0];
            ctx_sign <= neg_c;
            run_flag <= zero_c;
            px       <= px_s2;
            errval   <= neg_c ? -e_s2 : e_s2;
        end
    end

    // ---------------- Frame pixel counter ----------------
    logic [CW-1:0] pix_cnt;

    assign out_last = v3 && (pix_cnt == CW'(NPIX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_cnt <= '0;
        else if (v3 && out_ready)
            pix_cnt <= out_last ? '0 : pix_cnt + CW'(1);
    end

endmodule

// File: tb/tb_ctx_quant_pred.sv
module tb_ctx_quant_pred;

    localparam int DW   = 16;
    localparam int T1   = 3;
    localparam int T2   = 7;
    localparam int T3   = 21;
    localparam int NPIX = 11 * 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] ra = '0, rb = '0, rc = '0, rd = '0, rx = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [8:0]    ctx_idx;
    logic          ctx_sign;
    logic          run_flag;
    logic [DW-1:0] px;
    logic [DW:0]   errval;
    logic          out_last;

    ctx_quant_pred #(.DW(DW), .T1(T1), .T2(T2), .T3(T3), .IMAGE_W(11), .IMAGE_H(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd), .rx(rx),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctx_idx(ctx_idx), .ctx_sign(ctx_sign), .run_flag(run_flag),
        .px(px), .errval(errval), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit sgn;
        bit run;
        int p;
        int err;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   model_cnt  = 0;
    int   n_vec      = 0;
    int   n_bad      = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit   saw_block  = 0;
    int   seen_last  = 0;

    // ---------------- reference model ----------------
    function automatic int quant(int d);
        if (d <= -T3) return -4;
        if (d <= -T2) return -3;
        if (d <= -T1) return -2;
        if (d < 0)    return -1;
        if (d == 0)   return 0;
        if (d < T1)   return 1;
        if (d < T2)   return 2;
        if (d < T3)   return 3;
        return 4;
    endfunction

    function automatic exp_t model(int a, int b, int c, int d, int x);
        exp_t r;
        int q[3];
        int mx, mn, p, e, first;
        q[0] = quant(d - b);
        q[1] = quant(b - c);
        q[2] = quant(c - a);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        if (c >= mx)      p = mn;
        else if (c <= mn) p = mx;
        else              p = a + b - c;
        e = x - p;
        first = 0;
        for (int i = 0; i < 3; i++)
            if (first == 0 && q[i] != 0) first = q[i];
        r.sgn = (first < 0);
        if (r.sgn) begin
            for (int i = 0; i < 3; i++) q[i] = -q[i];
            e = -e;
        end
        r.idx  = 81 * q[0] + 9 * q[1] + q[2];
        r.run  = (first == 0);
        r.p    = p;
        r.err  = e;
        r.last = 0;
        return r;
    endfunction

    function automatic int clampp(int v);
        if (v < 0) return 0;
        if (v > 65535) return 65535;
        return v;
    endfunction

    task automatic push_exp(input exp_t e);
        exp_t t;
        t = e;
        t.last = (model_cnt == NPIX - 1);
        model_cnt = (model_cnt == NPIX - 1) ? 0 : model_cnt + 1;
        exp_q.push_back(t);
    endtask

    // Present one beat and hold it until accepted; expected result queued on acceptance.
    task automatic drive(input int a, input int b, input int c, input int d, input int x, input exp_t e);
        int guard;
        @(negedge clk);
        ra = DW'(a); rb = DW'(b); rc = DW'(c); rd = DW'(d); rx = DW'(x);
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                n_vec++; n_bad++;
                $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
                in_valid = 1'b0;
                return;
            end
        end
        push_exp(e);
    endtask

    task automatic drive_model(input int a, input int b, input int c, input int d, input int x);
        drive(a, b, c, d, x, model(a, b, c, d, x));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid: out_valid=%0b, required 0", out_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_edge: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic exp_t mk(int idx, bit sgn, bit run, int p, int err);
        exp_t r;
        r.idx = idx; r.sgn = sgn; r.run = run; r.p = p; r.err = err; r.last = 0;
        return r;
    endfunction

    // ---------------- ready generator ----------------
    initial forever begin
        @(negedge clk);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit   prev_stall;
        int   h_idx, h_err, h_p;
        bit   h_sgn, h_run, h_last;
        exp_t e;
        int   got_err;
        prev_stall = 0;
        h_idx = 0; h_err = 0; h_p = 0; h_sgn = 0; h_run = 0; h_last = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            if (in_valid && !in_ready) saw_block = 1;
            got_err = int'($signed(errval));
            if (prev_stall && out_valid) begin
                n_vec++;
                if (ctx_idx != h_idx[8:0] || ctx_sign != h_sgn || run_flag != h_run ||
                    int'(px) != h_p || got_err != h_err || out_last != h_last) begin
                    n_bad++;
                    $display("FAIL stall_hold: idx=%0d px=%0d err=%0d changed while stalled, required idx=%0d px=%0d err=%0d",
                             ctx_idx, px, got_err, h_idx, h_p, h_err);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (out_last) seen_last++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: idx=%0d px=%0d, required no output", ctx_idx, px);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(ctx_idx) != e.idx || ctx_sign != e.sgn || run_flag != e.run ||
                        int'(px) != e.p || got_err != e.err || out_last != e.last) begin
                        n_bad++;
                        $display("FAIL result: got idx=%0d sgn=%0b run=%0b px=%0d err=%0d last=%0b, required idx=%0d sgn=%0b run=%0b px=%0d err=%0d last=%0b",
                                 ctx_idx, ctx_sign, run_flag, px, got_err, out_last,
                                 e.idx, e.sgn, e.run, e.p, e.err, e.last);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            h_idx = int'(ctx_idx); h_sgn = ctx_sign; h_run = run_flag;
            h_p = int'(px); h_err = got_err; h_last = out_last;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int offs[9];
        int qs[9];
        int base;
        offs = '{-21, -7, -3, -1, 0, 2, 6, 20, 21};
        qs   = '{-4, -3, -2, -1, 0, 1, 2, 3, 4};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ctx_idx !== '0 || ctx_sign !== 1'b0 ||
            run_flag !== 1'b0 || px !== '0 || errval !== '0 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: out_valid=%0b in_ready=%0b idx=%0d px=%0d err=%0d, required 0/1/0/0/0",
                     out_valid, in_ready, ctx_idx, px, errval);
        end
        rst_n = 1'b1;

        // Hand-computed cases
        ready_mode = 0;
        drive(100, 100, 100, 100, 105, mk(0, 0, 1, 100, 5));
        drive(10, 50, 5, 80, 40, mk(358, 0, 0, 50, -10));
        drive(50, 50, 60, 48, 47, mk(105, 1, 0, 50, 3));
        for (int i = 0; i < 9; i++)
            drive(1000, 1000, 1000, 1000 + offs[i], 1000,
                  mk(81 * ((qs[i] < 0) ? -qs[i] : qs[i]), qs[i] < 0, qs[i] == 0, 1000, 0));
        drain();

        // Backpressure: downstream blocked while 8 beats are offered
        saw_block  = 0;
        ready_mode = 2;
        fork
            for (int i = 0; i < 8; i++) drive_model(200 + i, 220, 210 - i, 240 + 3 * i, 215);
            begin
                repeat (7) @(negedge clk);
                ready_mode = 0;
            end
        join
        drain();
        n_vec++;
        if (!saw_block) begin
            n_bad++;
            $display("FAIL stall_backpressure: in_ready never fell, required 0 once 3 beats held");
        end

        // Full frame plus one: out_last only on the 99th result
        do_reset();
        seen_last = 0;
        for (int i = 0; i < NPIX + 1; i++) begin
            base = $urandom_range(0, 65535);
            drive_model(clampp(base + $urandom_range(0, 40) - 20), base,
                        clampp(base + $urandom_range(0, 40) - 20),
                        clampp(base + $urandom_range(0, 60) - 30),
                        clampp(base + $urandom_range(0, 20) - 10));
        end
        drain();
        n_vec++;
        if (seen_last != 1) begin
            n_bad++;
            $display("FAIL frame_last_count: %0d out_last pulses, required 1", seen_last);
        end

        // Random valid/ready traffic with a reset mid-stream
        ready_mode = 1;
        for (int i = 0; i < 260; i++) begin
            if (i == 70) do_reset();
            if ($urandom_range(0, 4) == 0) idle();
            if ($urandom_range(0, 3) == 0)
                drive_model($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
                            $urandom_range(0, 65535), $urandom_range(0, 65535));
            else begin
                base = $urandom_range(0, 65535);
                drive_model(clampp(base + $urandom_range(0, 30) - 15), clampp(base + $urandom_range(0, 30) - 15),
                            clampp(base + $urandom_range(0, 30) - 15), clampp(base + $urandom_range(0, 50) - 25),
                            clampp(base + $urandom_range(0, 30) - 15));
            end
        end
        ready_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard stop in case anything above fails to terminate.
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
